// File: rtl/note_sequencer_if.sv
// Audio-controller side of the note sequencer: output-allowed / write handshake plus sample bus.
// The sequencer uses the master modport; the audio controller uses the slave modport.
interface note_sequencer_if;
    logic        audio_out_allowed;
    logic [31:0] sample;
    logic        sample_write;

    // sample_write is audio_out_allowed delayed by one cycle; sample is stable while it is high.
    modport master (
        input  audio_out_allowed,
        output sample,
        output sample_write
    );

    modport slave (
        output audio_out_allowed,
        input  sample,
        input  sample_write
    );
endinterface

// File: rtl/note_sequencer.sv
// Melody table sequencer with live-key arbitration and square-wave sample generation.
// Define PIANO_SEQ_LOOP_EN to make the loop input replay the table at its end marker.
module note_sequencer #(
    parameter int TICK_DIV  = 500000,
    parameter int GAP_TICKS = 2,
    parameter int SEQ_LEN   = 16,
    parameter int AMPLITUDE = 10000000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    input  logic [9:0]       live_keys,
    note_sequencer_if.master aud,
    output logic [18:0]      half_period,
    output logic             busy,
    output logic [3:0]       note_idx,
    output logic             src_live
);
    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    localparam int PW = $clog2(TICK_DIV);
    localparam int GW = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [3:0]    IDX_LAST   = 4'(SEQ_LEN - 1);
    localparam logic signed [31:0] AMP_POS = 32'(AMPLITUDE);
    localparam logic signed [31:0] AMP_NEG = -AMP_POS;

    function automatic logic [18:0] code_hp(input logic [3:0] code);
        case (code)
            4'd0:    code_hp = 19'd95554;
            4'd1:    code_hp = 19'd85132;
            4'd2:    code_hp = 19'd75842;
            4'd3:    code_hp = 19'd71586;
            4'd4:    code_hp = 19'd63775;
            4'd5:    code_hp = 19'd56818;
            4'd6:    code_hp = 19'd50620;
            4'd7:    code_hp = 19'd47778;
            4'd8:    code_hp = 19'd42568;
            4'd9:    code_hp = 19'd37922;
            default: code_hp = 19'd0;
        endcase
    endfunction

    // Entry = {code, dur}; dur == 0 marks the end of the melody.
    function automatic logic [11:0] seq_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    seq_entry = {4'd0, 8'd25};
            4'd1:    seq_entry = {4'd1, 8'd25};
            4'd2:    seq_entry = {4'd2, 8'd25};
            4'd3:    seq_entry = {4'd3, 8'd25};
            4'd4:    seq_entry = {4'd4, 8'd25};
            4'd5:    seq_entry = {4'd5, 8'd25};
            4'd6:    seq_entry = {4'd6, 8'd25};
            4'd7:    seq_entry = {4'd7, 8'd25};
            default: seq_entry = 12'h000;
        endcase
    endfunction

`ifdef PIANO_SEQ_LOOP_EN
    logic loop_en;
    assign loop_en = loop;
`else
    logic loop_en;
    logic unused_loop;
    assign loop_en     = 1'b0;
    assign unused_loop = loop;
`endif

    state_t          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic            wrap_q, wrap_d;
    logic [7:0]      remaining_q, remaining_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            busy_q, busy_d;
    logic            src_live_q, src_live_d;
    logic [18:0]     half_period_q, half_period_d;
    logic [18:0]     hp_prev_q, hp_prev_d;
    logic [18:0]     sq_cnt_q, sq_cnt_d;
    logic            phase_q, phase_d;
    logic [31:0]     sample_q, sample_d;
    logic            sample_write_q, sample_write_d;

    logic [11:0]     entry_cur, entry_nxt;
    logic [3:0]      key_code;
    logic            tick, advance;

    always_comb begin
        key_code = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (live_keys[i]) key_code = 4'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wrap_d      = wrap_q;
        remaining_d = remaining_q;
        presc_d     = presc_q;
        gap_cnt_d   = gap_cnt_q;
        advance     = 1'b0;
        entry_cur   = seq_entry(idx_q);
        tick        = (presc_q == PRESC_LAST);

        // Live keys own the tone: the whole sequencer holds its place.
        if (!src_live_q) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = LOAD;
                        idx_d   = 4'd0;
                        wrap_d  = 1'b0;
                    end
                end
                LOAD: begin
                    presc_d   = '0;
                    gap_cnt_d = '0;
                    if (entry_cur[7:0] != 8'd0 && !wrap_q) begin
                        state_d     = PLAY;
                        remaining_d = entry_cur[7:0];
                    end else if (loop_en && (idx_q != 4'd0 || wrap_q)) begin
                        idx_d  = 4'd0;
                        wrap_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                        idx_d   = 4'd0;
                        wrap_d  = 1'b0;
                    end
                end
                PLAY: begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        if (remaining_q == 8'd1) begin
                            remaining_d = 8'd0;
                            if (GAP_TICKS > 0) state_d = GAP;
                            else               advance = 1'b1;
                        end else begin
                            remaining_d = remaining_q - 8'd1;
                        end
                    end
                end
                GAP: begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        if (gap_cnt_q == GAP_LAST) begin
                            gap_cnt_d = '0;
                            advance   = 1'b1;
                        end else begin
                            gap_cnt_d = gap_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            // Finishing the last table slot is treated as reaching an end marker.
            if (advance) begin
                state_d = LOAD;
                if (idx_q == IDX_LAST) wrap_d = 1'b1;
                else                   idx_d  = idx_q + 4'd1;
            end
        end

        if (stop) begin
            state_d     = IDLE;
            idx_d       = 4'd0;
            wrap_d      = 1'b0;
            remaining_d = 8'd0;
            presc_d     = '0;
            gap_cnt_d   = '0;
        end
    end

    always_comb begin
        entry_nxt  = seq_entry(idx_d);
        busy_d     = (state_d != IDLE);
        src_live_d = $onehot(live_keys);
        if (src_live_d)            half_period_d = code_hp(key_code);
        else if (state_d == PLAY)  half_period_d = code_hp(entry_nxt[11:8]);
        else                       half_period_d = 19'd0;

        hp_prev_d = half_period_q;
        if (half_period_q == 19'd0 || half_period_q != hp_prev_q) begin
            sq_cnt_d = 19'd0;
            phase_d  = 1'b0;
        end else if (sq_cnt_q == half_period_q) begin
            sq_cnt_d = 19'd0;
            phase_d  = ~phase_q;
        end else begin
            sq_cnt_d = sq_cnt_q + 19'd1;
            phase_d  = phase_q;
        end

        if (half_period_q == 19'd0) sample_d = 32'd0;
        else                        sample_d = phase_q ? AMP_POS : AMP_NEG;
        sample_write_d = aud.audio_out_allowed;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            idx_q          <= 4'd0;
            wrap_q         <= 1'b0;
            remaining_q    <= 8'd0;
            presc_q        <= '0;
            gap_cnt_q      <= '0;
            busy_q         <= 1'b0;
            src_live_q     <= 1'b0;
            half_period_q  <= 19'd0;
            hp_prev_q      <= 19'd0;
            sq_cnt_q       <= 19'd0;
            phase_q        <= 1'b0;
            sample_q       <= 32'd0;
            sample_write_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            wrap_q         <= wrap_d;
            remaining_q    <= remaining_d;
            presc_q        <= presc_d;
            gap_cnt_q      <= gap_cnt_d;
            busy_q         <= busy_d;
            src_live_q     <= src_live_d;
            half_period_q  <= half_period_d;
            hp_prev_q      <= hp_prev_d;
            sq_cnt_q       <= sq_cnt_d;
            phase_q        <= phase_d;
            sample_q       <= sample_d;
            sample_write_q <= sample_write_d;
        end
    end

    assign half_period      = half_period_q;
    assign busy             = busy_q;
    assign note_idx         = idx_q;
    assign src_live         = src_live_q;
    assign aud.sample       = sample_q;
    assign aud.sample_write = sample_write_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: table playback, gaps, live-key override,
// stop priority, handshake, square-wave period and asynchronous reset.
module tb_note_sequencer;
    localparam logic [31:0] AMP_P = 32'd10000000;
    localparam logic [31:0] AMP_N = 32'hFF676980;
    localparam logic [18:0] HP_TAB [10] = '{19'd95554, 19'd85132, 19'd75842, 19'd71586, 19'd63775,
                                           19'd56818, 19'd50620, 19'd47778, 19'd42568, 19'd37922};

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, loop;
    logic [9:0]  live_keys;
    logic [18:0] half_period;
    logic        busy;
    logic [3:0]  note_idx;
    logic        src_live;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_wr;

    note_sequencer_if aud_if();

    note_sequencer #(
        .TICK_DIV  (4),
        .GAP_TICKS (1),
        .SEQ_LEN   (16),
        .AMPLITUDE (10000000)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (rst),
        .start       (start),
        .stop        (stop),
        .loop        (loop),
        .live_keys   (live_keys),
        .aud         (aud_if.master),
        .half_period (half_period),
        .busy        (busy),
        .note_idx    (note_idx),
        .src_live    (src_live)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b1; live_keys = 10'd0;
        aud_if.audio_out_allowed = 1'b0;
        step(3);
        check("rst_hp", 32'(half_period), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_idx", 32'(note_idx), 32'd0);
        check("rst_live", 32'(src_live), 32'd0);
        check("rst_sample", aud_if.sample, 32'd0);
        check("rst_wr", 32'(aud_if.sample_write), 32'd0);
        rst = 1'b0;
        step(2);

        // Full melody: LOAD 1 + PLAY 100 + GAP 4 cycles per note.
        start = 1'b1; step(1); start = 1'b0;
        check("load_busy", 32'(busy), 32'd1);
        check("load_hp", 32'(half_period), 32'd0);
        for (int k = 0; k < 8; k++) begin
            step(1);
            check("play_start_hp", 32'(half_period), 32'(HP_TAB[k]));
            check("play_idx", 32'(note_idx), 32'(k));
            step(99);
            check("play_end_hp", 32'(half_period), 32'(HP_TAB[k]));
            step(1);
            check("gap_hp", 32'(half_period), 32'd0);
            step(4);
            check("next_load_hp", 32'(half_period), 32'd0);
            check("next_load_idx", 32'(note_idx), 32'(k + 1));
            check("next_load_busy", 32'(busy), 32'd1);
        end
        step(1);
`ifdef PIANO_SEQ_LOOP_EN
        check("loop_busy", 32'(busy), 32'd1);
        check("loop_idx", 32'(note_idx), 32'd0);
        step(1);
        check("loop_hp", 32'(half_period), 32'(HP_TAB[0]));
        stop = 1'b1; step(1); stop = 1'b0;
        check("loop_stop_busy", 32'(busy), 32'd0);
`else
        check("end_busy", 32'(busy), 32'd0);
        check("end_hp", 32'(half_period), 32'd0);
`endif

        // Live key override freezes the sequencer for 50 cycles.
        loop = 1'b0;
        step(1);
        start = 1'b1; step(1); start = 1'b0;
        step(1);
        check("c4_hp", 32'(half_period), 32'(HP_TAB[0]));
        step(20);
        live_keys = 10'd32;
        step(1);
        check("live_src", 32'(src_live), 32'd1);
        check("live_hp", 32'(half_period), 32'(HP_TAB[5]));
        step(49);
        check("live_hold_hp", 32'(half_period), 32'(HP_TAB[5]));
        check("live_hold_busy", 32'(busy), 32'd1);
        check("live_hold_idx", 32'(note_idx), 32'd0);
        live_keys = 10'd0;
        step(1);
        check("resume_src", 32'(src_live), 32'd0);
        check("resume_hp", 32'(half_period), 32'(HP_TAB[0]));
        step(78);
        check("resume_end_hp", 32'(half_period), 32'(HP_TAB[0]));
        step(1);
        check("resume_gap_hp", 32'(half_period), 32'd0);
        step(5);
        check("note1_hp", 32'(half_period), 32'(HP_TAB[1]));
        check("note1_idx", 32'(note_idx), 32'd1);

        // stop beats start in the same cycle.
        stop = 1'b1; start = 1'b1; step(1); stop = 1'b0; start = 1'b0;
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_idx", 32'(note_idx), 32'd0);
        check("stop_hp", 32'(half_period), 32'd0);
        step(2);
        check("stop_stays_idle", 32'(busy), 32'd0);

        // Multi-hot keys fall back to the (idle) sequencer; one-hot edges take over.
        live_keys = 10'd3;
        step(2);
        check("multi_hp", 32'(half_period), 32'd0);
        check("multi_sample", aud_if.sample, 32'd0);
        check("multi_src", 32'(src_live), 32'd0);
        live_keys = 10'h200;
        step(1);
        check("e5_src", 32'(src_live), 32'd1);
        check("e5_hp", 32'(half_period), 32'(HP_TAB[9]));
        check("e5_busy", 32'(busy), 32'd0);
        live_keys = 10'h001;
        step(1);
        check("c4_key_hp", 32'(half_period), 32'(HP_TAB[0]));

        // Handshake: one write per allowed cycle, one cycle later.
        n_wr = 0;
        for (int i = 0; i < 20; i++) begin
            aud_if.audio_out_allowed = (i % 2 == 0);
            step(1);
            check("wr_follow", 32'(aud_if.sample_write), 32'(i % 2 == 0));
            if (aud_if.sample_write) begin
                n_wr++;
                check("wr_sample", aud_if.sample, AMP_N);
            end
        end
        aud_if.audio_out_allowed = 1'b0;
        check("wr_count", 32'(n_wr), 32'd10);
        step(1);
        check("wr_low", 32'(aud_if.sample_write), 32'd0);

        // Square period with E5: phase flips after 37923 cycles of counting.
        live_keys = 10'd0;
        step(3);
        live_keys = 10'h200;
        step(1);
        check("sq_first", aud_if.sample, 32'd0);
        step(1);
        check("sq_neg", aud_if.sample, AMP_N);
        step(37923);
        check("sq_neg_last", aud_if.sample, AMP_N);
        step(1);
        check("sq_pos", aud_if.sample, AMP_P);
        step(100);
        check("sq_pos_hold", aud_if.sample, AMP_P);

        // Asynchronous reset mid-note.
        live_keys = 10'd0;
        step(2);
        start = 1'b1; step(1); start = 1'b0;
        step(10);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_sample", aud_if.sample, AMP_N);
        #2 rst = 1'b1;
        #1;
        check("arst_hp", 32'(half_period), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_sample", aud_if.sample, 32'd0);
        step(2);
        rst = 1'b0;
        step(3);
        check("arst_no_resume", 32'(busy), 32'd0);
        check("arst_hp_after", 32'(half_period), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/note_sequencer.md
# note_sequencer

Melody sequencer and tone-source arbiter for the piano audio path. It steps through a fixed internal note table and arbitrates between that sequence and the live one-hot key switches. It generates the resulting square-wave sample and issues it to the audio controller using that controller's output-allowed / write handshake. It sits between the switch/key inputs and the audio controller, in place of a free-running tone generator.

## Interface
- TICK_DIV, 500000: CLOCK_50 cycles per duration tick (10 ms at 50 MHz); any value ≥ 2.
- GAP_TICKS, 2: silent ticks inserted after each note; 0 = no gap.
- SEQ_LEN, 16: note-table depth; power of two, ≤ 16.
- AMPLITUDE, 10000000: square-wave magnitude.
- CLOCK_50  input  1  system clock; the only clock in the block.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  single-cycle play request; ignored while busy.
- stop  input  1  abort; takes priority over start.
- loop  input  1  replay the table from entry 0 on end marker (see Configuration).
- live_keys  input  10  SW one-hot; bit0 = C4 … bit9 = E5.
- audio_out_allowed  input  1  audio controller has FIFO space.
- sample  output  32  signed square-wave sample, same on both channels.
- sample_write  output  1  write strobe to the audio controller.
- half_period  output  19  current half-period count; 0 = silent.
- busy  output  1  sequencer not IDLE.
- note_idx  output  4  table index being played.
- src_live  output  1  live keys currently own the tone.

## Operation
- Note codes 0–9 map to half-period counts 95554, 85132, 75842, 71586, 63775, 56818, 50620, 47778, 42568, 37922 (C4–E5). Codes 10–15 are rest.
- Table entry = {code[3:0], dur[7:0]}. dur = 0 is the end marker. The default table is C4…C5 (codes 0,1,2,3,4,5,6,7) with dur 25 each, followed by the end marker.
- FSM states:
  - IDLE → LOAD on start. Sets idx = 0.
  - LOAD (1 cycle) reads entry[idx]:
    - dur ≠ 0 → PLAY, remaining = dur.
    - dur = 0 and looping and idx ≠ 0 → LOAD, idx = 0.
    - Otherwise → IDLE.
  - PLAY: remaining decrements on each tick. At 0 → GAP if GAP_TICKS > 0, else → LOAD with idx + 1.
  - GAP: silent for GAP_TICKS ticks, then → LOAD with idx + 1.
  - idx wrap: idx = SEQ_LEN − 1 completing behaves as if the next entry were the end marker.
- Tick prescaler: counts only in PLAY and GAP, and is cleared in LOAD.
- stop in any state → IDLE on the next edge; idx and timers are cleared.
- Arbitration:
  - live_keys with exactly one bit set → src_live = 1, and half_period takes that key's count.
  - While src_live = 1, the sequencer's prescaler, remaining count and state are frozen. The sequence resumes where it stopped once the keys release.
  - Zero or multi-hot live_keys → sequencer output. half_period is nonzero only in PLAY with codes 0–9.
- Square generator:
  - Counter runs 0…half_period, toggling phase at the terminal count.
  - Counter and phase are cleared whenever half_period changes value or equals 0.
  - sample = +AMPLITUDE when phase = 1, −AMPLITUDE when phase = 0, and 0 when half_period = 0. Arithmetic is 32-bit two's complement.
- Handshake: sample_write = audio_out_allowed, registered. sample holds its value in the cycle sample_write is high. No writes are issued while audio_out_allowed is low.

## Timing
- All outputs reset to 0. The FSM resets to IDLE.
- LOAD lasts 1 cycle. PLAY lasts exactly dur × TICK_DIV cycles. GAP lasts exactly GAP_TICKS × TICK_DIV cycles. Each frozen (src_live) cycle adds one cycle to these.
- busy rises 1 cycle after start is sampled, and falls 1 cycle after the final LOAD or after stop.
- half_period and src_live are registered: 1-cycle latency from live_keys or state.
- sample has 1-cycle latency from half_period / phase. sample_write has 1-cycle latency from audio_out_allowed.
- start and stop in the same cycle: stop wins; the block stays IDLE.
- Reset asserted mid-note: all state and outputs are immediately 0. Play does not resume on deassertion.

## Configuration
- PIANO_SEQ_LOOP_EN defined: loop is honoured as described above.
- PIANO_SEQ_LOOP_EN undefined: loop is ignored, and the end marker always returns the FSM to IDLE. The port remains present.

## Test plan
- TICK_DIV = 4, GAP_TICKS = 1. Pulse start → note_idx 0 … 7, half_period 95554 for 100 cycles, 0 for 4 cycles, then 85132, and so on. busy falls after entry 8 is loaded.
- live_keys = 10'd32 asserted mid-C4 for 50 cycles → half_period = 56818 and src_live = 1. After release, C4 resumes with its remaining count unchanged.
- live_keys = 10'd3 (multi-hot) while IDLE → half_period = 0, sample = 0, src_live = 0.
- stop and start pulsed in the same cycle during PLAY → IDLE next cycle, busy = 0, note_idx = 0, half_period = 0.
- loop = 1 with PIANO_SEQ_LOOP_EN defined → after entry 7, idx returns to 0 and busy stays 1. With the macro undefined, busy drops.
- audio_out_allowed toggling every other cycle with half_period = 95554 → one sample_write per allowed cycle; sample alternates ±10000000 every 95555 cycles; no write occurs while allowed = 0.
